mdu_iterative: RTL and testbench

- Multi-cycle multiply/divide unit for the MIPS core, directly downstream of the register file.
- Consumes the two register-file read operands (RD1 -> a, RD2 -> b) for MULT/MULTU/DIV/DIVU and holds the HI/LO architectural registers.
- The datapath reads HI/LO for MFHI/MFLO and writes them for MTHI/MTLO.
- Controller stalls the pipeline while busy is high.

---
 rtl/mdu_if.sv | 27 ++
 rtl/mdu_iterative.sv | 125 ++++++++++++
 tb/tb_mdu_iterative.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Operand, control and HI/LO result bundle between the register file/datapath
// and the iterative multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per clock, with sign fix-up into HI/LO.
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic               is_div, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_part, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] step_next, prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divide: acc = {partial remainder, dividend/quotient}. A zero divisor forces
  // every subtract to "succeed", giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    abs_a      = '0;
    abs_b      = '0;
    mul_sum    = '0;
    div_part   = '0;
    div_diff   = '0;
    div_ge     = 1'b0;
    step_next  = '0;
    prod_fixed = '0;
    quot_fixed = '0;
    rem_fixed  = '0;

    abs_a = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_part - {1'b0, mcand};
    div_ge   = div_zero || !div_diff[WIDTH];

    if (!is_div)     step_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_ge) step_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else             step_next = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    prod_fixed = (sign_a ^ sign_b) ? -acc : acc;
    quot_fixed = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wd;
          if (bus.lo_we) lo_q <= bus.wd;
          if (bus.start) begin
            cnt      <= '0;
            is_div   <= bus.op[1];
            sign_a   <= bus.op[0] & bus.a[WIDTH-1];
            sign_b   <= bus.op[0] & bus.b[WIDTH-1];
            div_zero <= bus.op[1] && (bus.b == '0);
            mcand    <= abs_b;
            acc      <= {{WIDTH{1'b0}}, abs_a};
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            lo_q <= div_zero ? '1 : quot_fixed;
            hi_q <= rem_fixed;
          end else begin
            hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
            lo_q <= prod_fixed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed MULT/DIV vectors, HI/LO writes,
// ignored mid-flight starts and an aborting reset.
module tb_mdu_iterative;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(WIDTH)) mif ();

  mdu_iterative #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every done pulse must retire exactly one queued expectation.
  always @(negedge clk) begin
    if (mif.done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pulse");
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput({mon_e.name, "_hi"}, mif.hi, mon_e.hi);
        checkOutput({mon_e.name, "_lo"}, mif.lo, mon_e.lo);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hi_e, input logic [31:0] lo_e,
                               input string name, input int disturb_at);
    int lat;
    int busy_n;
    mif.start = 1'b1;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    sb_q.push_back('{hi_e, lo_e, name});
    @(negedge clk);
    mif.start = 1'b0;
    mif.a     = ~a;
    mif.b     = ~b;
    checkOutput({name, "_busy_rise"}, {31'b0, mif.busy}, 32'd1);
    lat    = 1;
    busy_n = 0;
    while (mif.done !== 1'b1 && lat < 100) begin
      if (mif.busy === 1'b1) busy_n++;
      if (lat == disturb_at) begin
        mif.start = 1'b1;
        mif.op    = 2'b00;
        mif.a     = 32'd5;
        mif.b     = 32'd1;
        mif.hi_we = 1'b1;
        mif.wd    = 32'h0000_AAAA;
      end else if (lat == disturb_at + 1) begin
        mif.start = 1'b0;
        mif.hi_we = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'd34);
    checkOutput({name, "_busy_cycles"}, 32'(busy_n), 32'd33);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pre_done;
    mif.start = 1'b0;
    mif.op    = 2'b00;
    mif.a     = '0;
    mif.b     = '0;
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    mif.wd    = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, mif.busy}, 32'd0);
    checkOutput("reset_done", {31'b0, mif.done}, 32'd0);
    checkOutput("reset_hi", mif.hi, 32'd0);
    checkOutput("reset_lo", mif.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive calls also launch each op in the cycle done is high.
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7", 0);
    applyStimulus(2'b01, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0000, "mult_minx2", 0);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2", 0);
    applyStimulus(2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2", 0);
    applyStimulus(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7", 0);
    applyStimulus(2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0", 0);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0", 0);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 0);
    applyStimulus(2'b10, 32'd1000, 32'd9, 32'd1, 32'd111, "divu_disturbed", 10);

    mif.hi_we = 1'b1;
    mif.wd    = 32'h0000_0055;
    @(negedge clk);
    mif.hi_we = 1'b0;
    checkOutput("mthi_hi", mif.hi, 32'h0000_0055);
    checkOutput("mthi_lo_kept", mif.lo, 32'd111);

    mif.lo_we = 1'b1;
    mif.wd    = 32'h0000_CAFE;
    @(negedge clk);
    mif.lo_we = 1'b0;
    checkOutput("mtlo_lo", mif.lo, 32'h0000_CAFE);
    checkOutput("mtlo_hi_kept", mif.hi, 32'h0000_0055);

    mif.start = 1'b1;
    mif.op    = 2'b01;
    mif.a     = 32'd3;
    mif.b     = 32'd5;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'b0, mif.busy}, 32'd0);
    checkOutput("abort_done", {31'b0, mif.done}, 32'd0);
    checkOutput("abort_hi", mif.hi, 32'd0);
    checkOutput("abort_lo", mif.lo, 32'd0);
    pre_done = done_cnt;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_cnt), 32'(pre_done));

    applyStimulus(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_after_abort", 0);
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
